// File: rtl/uart_tx_block128.sv
// Serialises 128-bit blocks as 16 UART 8N1 bytes, MSB byte first, LSB bit first.
// A holding register lets the next block queue up while the active one is on the wire.
module uart_tx_block128 #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned INTER_BYTE_GAP = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [127:0] block_in_i,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    output logic         tx_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned GapW  = $clog2(INTER_BYTE_GAP + 2);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(INTER_BYTE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [3:0]         byte_q, byte_d;
    logic [127:0]       active_q, active_d;
    logic [127:0]       hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               bit_end;
    logic               byte_end;
    logic               blk_end;
    logic               active_free;

    assign accept = block_valid_i && !hold_valid_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            byte_q       <= '0;
            active_q     <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            byte_q       <= byte_d;
            active_q     <= active_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        byte_d       = byte_q;
        active_d     = active_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        byte_end     = 1'b0;
        blk_end      = 1'b0;
        active_free  = 1'b0;

        bit_end = (state_q != StIdle) && (baud_q == BaudLast);
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (INTER_BYTE_GAP == 0) begin
                        byte_end = 1'b1;
                    end else begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end
            end
            StGap: begin
                if (bit_end) begin
                    if (gap_q == GapLast) begin
                        byte_end = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (byte_end) begin
            if (byte_q == 4'd15) begin
                blk_end = 1'b1;
                state_d = StIdle;
            end else begin
                byte_d  = byte_q + 4'd1;
                state_d = StStart;
            end
        end

        // The active register may reload while idle or on the final cycle of its block,
        // which is what makes queued blocks run back to back without an idle bit.
        active_free = (state_q == StIdle) || blk_end;

        if (active_free && hold_valid_q) begin
            active_d     = hold_q;
            hold_valid_d = 1'b0;
            state_d      = StStart;
            byte_d       = '0;
            baud_d       = '0;
        end else if (accept && active_free) begin
            active_d = block_in_i;
            state_d  = StStart;
            byte_d   = '0;
            baud_d   = '0;
        end else if (accept) begin
            hold_d       = block_in_i;
            hold_valid_d = 1'b1;
        end
    end

    // Outputs are computed from next state so the registered tx lines up with state_q.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = blk_end;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = active_d[{~byte_d, bit_d}];
            default: tx_d = 1'b1;
        endcase
    end

    assign block_ready_o = ~hold_valid_q;
    assign tx_o          = tx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
